wide_lzc_sequencer: RTL and testbench

Multi-cycle leading-zero counter for wide operands (default 128 bits) built around a single narrow combinational `leading_zero_cnt` instance. The operand is scanned one chunk per cycle, MSB chunk first, with early termination at the first non-zero chunk. It sits between an operand producer (e.g. a normalisation stage of a wide fixed/float unit) and its consumer, behind valid/ready handshakes on both sides.

---
 rtl/wide_lzc_defs_pkg.sv | 27 ++
 rtl/wide_lzc_sequencer_lzc.sv | 24 ++
 rtl/wide_lzc_sequencer.sv | 119 +++++++++++
 tb/tb_wide_lzc_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wide_lzc_defs_pkg.sv
// Shared state encoding and size helpers for the wide leading-zero sequencer.
package wide_lzc_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned DEF_DATA_W  = 128;
    localparam int unsigned DEF_CHUNK_W = 32;

    // Number of chunks scanned for a given operand/chunk width pair.
    function automatic int unsigned num_chunks(input int unsigned data_w,
                                               input int unsigned chunk_w);
        return data_w / chunk_w;
    endfunction

    // Chunk index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned NUM_CHUNKS = num_chunks(DEF_DATA_W, DEF_CHUNK_W);
    localparam int unsigned IDX_W      = idx_width(NUM_CHUNKS);

endpackage

// File: rtl/wide_lzc_sequencer_lzc.sv
// Narrow combinational leading-zero counter; returns WI_SZ for an all-zero input.
module leading_zero_cnt #(
    parameter int unsigned WI_SZ = 32,
    parameter int unsigned WO_SZ = $clog2(WI_SZ) + 1
) (
    input  logic [WI_SZ-1:0] in_vec,
    output logic [WO_SZ-1:0] lz_cnt_c
);

    logic found;

    // Priority scan from the MSB; the first set bit fixes the count.
    always_comb begin
        lz_cnt_c = WO_SZ'(WI_SZ);
        found    = 1'b0;
        for (int i = WI_SZ - 1; i >= 0; i--) begin
            if (!found && in_vec[i]) begin
                lz_cnt_c = WO_SZ'(WI_SZ - 1 - i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wide_lzc_sequencer.sv
// Multi-cycle leading-zero counter: scans a wide operand MSB chunk first,
// stopping at the first non-zero chunk, behind valid/ready on both sides.
module wide_lzc_sequencer
    import wide_lzc_defs::*;
#(
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned CHUNK_W = 32,
    parameter int unsigned CNT_W   = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_zero,
    output logic              busy
);

    localparam int unsigned NCHUNK = num_chunks(DATA_W, CHUNK_W);
    localparam int unsigned IW     = idx_width(NCHUNK);
    localparam int unsigned LZ_W   = $clog2(CHUNK_W) + 1;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    out_count_q, out_count_d;
    logic                out_zero_q, out_zero_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic [LZ_W-1:0]     lz_c;

    leading_zero_cnt #(
        .WI_SZ (CHUNK_W),
        .WO_SZ (LZ_W)
    ) u_lzc (
        .in_vec   (shreg_q[DATA_W-1 -: CHUNK_W]),
        .lz_cnt_c (lz_c)
    );

    // Ready is a state decode, held low while reset is asserted.
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_zero  = out_zero_q;
    assign busy      = busy_q;

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        out_count_d = out_count_q;
        out_zero_d  = out_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (lz_c != LZ_W'(CHUNK_W)) begin
                    out_count_d = acc_q + CNT_W'(lz_c);
                    out_zero_d  = 1'b0;
                    state_d     = ST_DONE;
                end else if (idx_q == IW'(NCHUNK - 1)) begin
                    out_count_d = CNT_W'(DATA_W);
                    out_zero_d  = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    acc_d   = acc_q + CNT_W'(CHUNK_W);
                    shreg_d = shreg_q << CHUNK_W;
                    idx_d   = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            out_count_q <= '0;
            out_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_count_q <= out_count_d;
            out_zero_q  <= out_zero_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_wide_lzc_sequencer.sv
// Self-checking bench for wide_lzc_sequencer at default parameters.
module tb_wide_lzc_sequencer;

    localparam int unsigned DATA_W  = 128;
    localparam int unsigned CHUNK_W = 32;
    localparam int unsigned CNT_W   = $clog2(DATA_W) + 1;
    localparam int unsigned NCHUNK  = DATA_W / CHUNK_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CNT_W-1:0]  out_count;
    logic              out_zero;
    logic              busy;

    int checks = 0;
    int errors = 0;

    wide_lzc_sequencer #(
        .DATA_W  (DATA_W),
        .CHUNK_W (CHUNK_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: zeros above the most significant set bit.
    function automatic int ref_lz(input logic [DATA_W-1:0] d);
        for (int i = DATA_W - 1; i >= 0; i--)
            if (d[i]) return DATA_W - 1 - i;
        return DATA_W;
    endfunction

    function automatic int ref_lat(input logic [DATA_W-1:0] d);
        int k;
        k = ref_lz(d) / CHUNK_W;
        return ((k < NCHUNK - 1) ? k : NCHUNK - 1) + 1;
    endfunction

    // Transaction-level model: pending operand, countdown, presented result.
    bit m_started = 0;
    bit m_busy = 0;
    bit m_valid = 0;
    int m_remain = 0;
    int m_pend_cnt = 0;
    int m_count = 0;
    bit m_zero = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_started = 1;
            m_busy = 0; m_valid = 0; m_count = 0; m_zero = 0; m_remain = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1;
                m_pend_cnt = ref_lz(in_data);
                m_remain = ref_lat(in_data);
            end
        end else if (!m_valid) begin
            m_remain = m_remain - 1;
            if (m_remain == 0) begin
                m_valid = 1;
                m_count = m_pend_cnt;
                m_zero = (m_pend_cnt == DATA_W);
            end
        end else if (out_ready) begin
            m_valid = 0;
            m_busy = 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            check("out_valid", out_valid, m_valid);
            check("busy", busy, m_busy);
            check("in_ready", in_ready, rst_n && !m_busy);
            if (m_valid || !rst_n) begin
                check("out_count", out_count, m_count);
                check("out_zero", out_zero, m_zero);
            end
        end
    end

    // Offer an operand, then measure latency and the returned result.
    task automatic run_op(input logic [DATA_W-1:0] d, input int exp_cnt,
                          input bit exp_zero, input int exp_lat, input string tag);
        int n;
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({tag, "_accept_timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_count"}, out_count, exp_cnt);
        check({tag, "_zero"}, out_zero, exp_zero);
        if (out_ready) begin
            @(negedge clk);
            check({tag, "_valid_one_cycle"}, out_valid, 0);
        end
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        logic [CNT_W-1:0]  held_cnt;
        logic              held_zero;
        int                n;

        // Pin the reference model against hand-computed values.
        v = {1'b1, 127'b0};
        check("ref_msb", ref_lz(v), 0);
        v = 128'h0000_0000_0001_0000_0000_0000_0000_0000;
        check("ref_chunk1", ref_lz(v), 47);
        check("ref_chunk1_lat", ref_lat(v), 2);
        v = 128'h1;
        check("ref_one", ref_lz(v), 127);
        check("ref_one_lat", ref_lat(v), 4);
        v = '0;
        check("ref_zero", ref_lz(v), 128);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_zero", out_zero, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Directed cases with literal expectations.
        run_op({1'b1, 127'b0}, 0, 1'b0, 1, "msb");
        run_op(128'h0000_0000_0001_0000_0000_0000_0000_0000, 47, 1'b0, 2, "chunk1");
        run_op(128'h1, 127, 1'b0, 4, "one");
        run_op('0, 128, 1'b1, 4, "zero");
        run_op(128'h0000_0000_0000_0000_8000_0000_0000_0000, 64, 1'b0, 3, "chunk2");

        // Backpressure with a second operand pending.
        out_ready = 1'b0;
        run_op(128'h0000_0000_0000_0000_0000_0000_0000_00F0, 120, 1'b0, 4, "bp_a");
        in_valid = 1'b1;
        in_data  = 128'h0000_4000_0000_0000_0000_0000_0000_0000;
        held_cnt  = out_count;
        held_zero = out_zero;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_held", out_valid, 1);
            check("bp_count_stable", out_count, held_cnt);
            check("bp_zero_stable", out_zero, held_zero);
            check("bp_in_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake_valid", out_valid, 0);
        check("bp_ready_after", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_accepted", busy, 1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_second_count", out_count, 17);
        @(negedge clk);

        // Reset during the scan of an operand of 1.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 128'h1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", out_count, 0);
        check("mid_rst_zero", out_zero, 0);
        check("mid_rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_rst_no_result", out_valid, 0);
        end

        // Sparse-high-bit random operands against the reference model.
        for (int t = 0; t < 300; t++) begin
            int p;
            p = $urandom_range(DATA_W - 1, 0);
            v = {$urandom, $urandom, $urandom, $urandom};
            v = v >> (DATA_W - 1 - p);
            v[p] = 1'b1;
            if ($urandom_range(9, 0) == 0) v = '0;
            out_ready = ($urandom_range(3, 0) != 0);
            run_op(v, ref_lz(v), (v == '0), ref_lat(v), "rand");
            out_ready = 1'b1;
            n = 0;
            while (out_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
